processor_mc: RTL
=================

Name: processor_mc

Overview:
- Multi-cycle successor to the single-cycle RV32 subset core. Executes the same instruction set: add, sub, and, or, slt, addi, lw, sw, beq, blt, jal, jalr, lui.
- Built around an explicit FSM with valid/ready handshakes on the instruction and data memory ports, so memories with wait states are supported.
- Register count and reset vector are parametrised. Illegal and misaligned accesses trap.
- Sits as the CPU top under the SoC memory wrapper.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, architectural register count. Legal values: 16 (RV32E) or 32. A register field >= NREGS is an illegal instruction.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- PC  out  32  current instruction address
- instr_req  out  1  fetch request, high only in FETCH
- instruction  in  32  instruction word; sampled when instr_req & instr_valid
- instr_valid  in  1  instruction memory ready
- WE  out  1  data store strobe, held until data_ready
- RE  out  1  data load strobe, held until data_ready
- address_to_mem  out  32  data address
- data_to_mem  out  32  store data
- data_from_mem  in  32  load data; sampled when RE & data_ready
- data_ready  in  1  data memory handshake complete
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky; core halted

Behaviour:
- Reset (asynchronous) values:
  - PC=RESET_PC, state=FETCH, all registers 0.
  - instr_req=1 after release; WE=RE=retire=trap=0; address_to_mem=data_to_mem=0.
  - Reset mid-MEM drops WE/RE immediately.
- FETCH: instr_req=1. On instr_valid, latch the instruction into IR and go to DECODE. Otherwise stay.
- DECODE: read rs1/rs2 into latches A/B, sign-extend the immediate (I/S/B/J; U = imm<<12), go to EXEC. Unknown opcode/funct or register index >= NREGS -> TRAP.
- EXEC:
  - ALU/addi/lui: latch result, go to WB.
  - lw/sw: compute address A+imm. If address[1:0]!=0 -> TRAP, else go to MEM.
  - beq/blt (blt signed): target=PC+imm. If taken and target[1:0]!=0 -> TRAP, else PC<=taken?target:PC+4. Pulse retire, go to FETCH.
  - jal: rd<=PC+4, PC<=PC+imm.
  - jalr: rd<=PC+4, PC<=(A+imm)&~1.
  - For jal/jalr, target[1] set -> TRAP with rd unwritten. Otherwise pulse retire, go to FETCH.
- MEM: hold RE (lw) or WE (sw) with a stable address and data until data_ready.
  - lw: latch data_from_mem, go to WB.
  - sw: PC+=4, pulse retire, go to FETCH.
  - data_ready in the first MEM cycle is legal (zero wait).
- WB: rd<=result (writes to x0 ignored), PC+=4, pulse retire, go to FETCH.
- TRAP: trap=1, all strobes 0, PC frozen at the faulting instruction. Only reset leaves this state.
- Latency with zero-wait memories, FETCH through retire:
  - ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch/jal/jalr: 3 cycles.
  - Each wait cycle adds 1.
- Arithmetic:
  - 32-bit, wrap-around on add/sub/PC.
  - slt/blt signed two's complement; beq on equality.
- Register reads occur in DECODE, after the previous WB, so no forwarding is needed.

Optional Feature:
- Macro: PROCESSOR_MC_DIV_EN.
- When defined:
  - divu/remu (opcode 0110011, funct7 0000001, funct3 101/111) are decoded.
  - EXEC enters a DIV state running a restoring divider, 1 quotient bit per cycle. DIV lasts 32 cycles, then WB.
  - Divide by zero: divu=32'hFFFF_FFFF, remu=dividend, still 32 cycles.
  - Reset during DIV aborts it with no register write.
- When undefined: those encodings -> TRAP.

Test Plan:
- Reset during MEM: reset asserted while WE=1 -> WE=0 combinationally (no clock edge needed); PC=RESET_PC. After release, first instr_req on the next cycle.
- addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1 with instr_valid always 1 -> x3=2, x4=1; retire every 4 cycles.
- sw x3,8(x0) with data_ready delayed 3 cycles -> WE held 4 cycles, address_to_mem=8, data_to_mem=2. Then lw x5,8(x0) -> x5=2, RE asserted, lw retires in 5+wait cycles.
- Branches:
  - blt x2,x1,+8 at PC=0x20 -> PC=0x28.
  - beq x1,x2 not taken -> PC+4.
  - jal x1,-16 at 0x40 -> x1=0x44, PC=0x30.
- Traps:
  - lw from address 0x6 -> trap=1, no RE, PC frozen.
  - Opcode 7'b1111111 -> trap.
  - With NREGS=16, add x17,x1,x1 -> trap.
- With PROCESSOR_MC_DIV_EN: divu 100/7 -> 14 and remu -> 2, 32 DIV cycles. divu x/0 -> 0xFFFFFFFF. Without the macro the same encoding -> trap.

Source files
------------

// File: rtl/processor_mc.sv
// Multi-cycle RV32 subset core (add/sub/and/or/slt/addi/lw/sw/beq/blt/jal/jalr/lui) with handshaked memory ports.
// Defining PROCESSOR_MC_DIV_EN adds divu/remu through a 32-cycle restoring divider; otherwise they trap.
module processor_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC,
    output logic        instr_req,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        WE,
    output logic        RE,
    output logic [31:0] address_to_mem,
    output logic [31:0] data_to_mem,
    input  logic [31:0] data_from_mem,
    input  logic        data_ready,
    output logic        retire,
    output logic        trap,
    output logic [2:0]  dbg_state_o
);

    // Handshakes: a transfer happens on the rising edge where the request (instr_req, or RE/WE)
    // and the responder's valid/ready are both high; request, address and data are held until then.
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DIV, S_TRAP} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_LUI, OP_LW,
        OP_SW, OP_BEQ, OP_BLT, OP_JAL, OP_JALR, OP_DIVU, OP_REMU
    } op_t;

    localparam int          RW      = $clog2(NREGS);
    localparam logic [5:0]  NREGS_L = 6'(NREGS);

    state_t      state_q;
    op_t         op_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, res_q, addr_q, wdata_q;
    logic        we_q, re_q, retire_q, trap_q;
    logic [31:0] rf_q [NREGS];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode  = ir_q[6:0];
    assign rd_idx  = ir_q[11:7];
    assign funct3  = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign funct7  = ir_q[31:25];
    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign imm_u   = {ir_q[31:12], 12'd0};

    op_t         dec_op;
    logic        dec_legal, use_rd, use_rs1, use_rs2;
    logic [31:0] dec_imm;

    always_comb begin
        dec_op    = OP_ADD;
        dec_legal = 1'b1;
        dec_imm   = imm_i;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opcode)
            7'b0110011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec_op = OP_ADD;
                    10'b0100000_000: dec_op = OP_SUB;
                    10'b0000000_111: dec_op = OP_AND;
                    10'b0000000_110: dec_op = OP_OR;
                    10'b0000000_010: dec_op = OP_SLT;
`ifdef PROCESSOR_MC_DIV_EN
                    10'b0000001_101: dec_op = OP_DIVU;
                    10'b0000001_111: dec_op = OP_REMU;
`endif
                    default:         dec_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec_op = OP_ADDI; use_rd = 1'b1; use_rs1 = 1'b1;
                dec_legal = (funct3 == 3'b000);
            end
            7'b0110111: begin
                dec_op = OP_LUI; dec_imm = imm_u; use_rd = 1'b1;
            end
            7'b0000011: begin
                dec_op = OP_LW; use_rd = 1'b1; use_rs1 = 1'b1;
                dec_legal = (funct3 == 3'b010);
            end
            7'b0100011: begin
                dec_op = OP_SW; dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_legal = (funct3 == 3'b010);
            end
            7'b1100011: begin
                dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
                if (funct3 == 3'b000)      dec_op = OP_BEQ;
                else if (funct3 == 3'b100) dec_op = OP_BLT;
                else                       dec_legal = 1'b0;
            end
            7'b1101111: begin
                dec_op = OP_JAL; dec_imm = imm_j; use_rd = 1'b1;
            end
            7'b1100111: begin
                dec_op = OP_JALR; use_rd = 1'b1; use_rs1 = 1'b1;
                dec_legal = (funct3 == 3'b000);
            end
            default: dec_legal = 1'b0;
        endcase
        // RV32E builds have fewer registers; any out-of-range field is illegal.
        if ((use_rd && {1'b0, rd_idx} >= NREGS_L) || (use_rs1 && {1'b0, rs1_idx} >= NREGS_L) ||
            (use_rs2 && {1'b0, rs2_idx} >= NREGS_L))
            dec_legal = 1'b0;
    end

    logic [31:0] addr_calc, br_target, jump_target, pc_plus4, alu_res;
    logic        taken;

    assign addr_calc   = a_q + imm_q;
    assign br_target   = pc_q + imm_q;
    assign jump_target = (op_q == OP_JALR) ? {addr_calc[31:1], 1'b0} : br_target;
    assign pc_plus4    = pc_q + 32'd4;
    assign taken       = (op_q == OP_BEQ) ? (a_q == b_q) : ($signed(a_q) < $signed(b_q));

    always_comb begin
        alu_res = a_q + b_q;
        case (op_q)
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
            OP_ADDI: alu_res = addr_calc;
            OP_LUI:  alu_res = imm_q;
            default: ;
        endcase
    end

`ifdef PROCESSOR_MC_DIV_EN
    logic [31:0] div_rem_q, div_quo_q, div_rem_d, div_quo_d;
    logic [4:0]  div_cnt_q;
    logic [32:0] div_shift, div_diff;

    // Restoring step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    assign div_shift = {div_rem_q, div_quo_q[31]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_rem_d = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
    assign div_quo_d = {div_quo_q[30:0], ~div_diff[32]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            op_q     <= OP_ADD;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            res_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
`ifdef PROCESSOR_MC_DIV_EN
            div_rem_q <= '0;
            div_quo_q <= '0;
            div_cnt_q <= '0;
`endif
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_q    <= instruction;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= rf_q[rs1_idx[RW-1:0]];
                    b_q   <= rf_q[rs2_idx[RW-1:0]];
                    imm_q <= dec_imm;
                    op_q  <= dec_op;
                    if (dec_legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LW, OP_SW: begin
                            if (addr_calc[1:0] != 2'b00) begin
                                state_q <= S_TRAP;
                                trap_q  <= 1'b1;
                            end else begin
                                addr_q  <= addr_calc;
                                wdata_q <= b_q;
                                we_q    <= (op_q == OP_SW);
                                re_q    <= (op_q == OP_LW);
                                state_q <= S_MEM;
                            end
                        end
                        OP_BEQ, OP_BLT: begin
                            if (taken && br_target[1:0] != 2'b00) begin
                                state_q <= S_TRAP;
                                trap_q  <= 1'b1;
                            end else begin
                                pc_q     <= taken ? br_target : pc_plus4;
                                retire_q <= 1'b1;
                                state_q  <= S_FETCH;
                            end
                        end
                        OP_JAL, OP_JALR: begin
                            if (jump_target[1:0] != 2'b00) begin
                                state_q <= S_TRAP;
                                trap_q  <= 1'b1;
                            end else begin
                                if (rd_idx != 5'd0) rf_q[rd_idx[RW-1:0]] <= pc_plus4;
                                pc_q     <= jump_target;
                                retire_q <= 1'b1;
                                state_q  <= S_FETCH;
                            end
                        end
`ifdef PROCESSOR_MC_DIV_EN
                        OP_DIVU, OP_REMU: begin
                            div_rem_q <= '0;
                            div_quo_q <= a_q;
                            div_cnt_q <= '0;
                            state_q   <= S_DIV;
                        end
`endif
                        default: begin
                            res_q   <= alu_res;
                            state_q <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (data_ready) begin
                        we_q <= 1'b0;
                        re_q <= 1'b0;
                        if (re_q) begin
                            res_q   <= data_from_mem;
                            state_q <= S_WB;
                        end else begin
                            pc_q     <= pc_plus4;
                            retire_q <= 1'b1;
                            state_q  <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (rd_idx != 5'd0) rf_q[rd_idx[RW-1:0]] <= res_q;
                    pc_q     <= pc_plus4;
                    retire_q <= 1'b1;
                    state_q  <= S_FETCH;
                end
`ifdef PROCESSOR_MC_DIV_EN
                S_DIV: begin
                    div_rem_q <= div_rem_d;
                    div_quo_q <= div_quo_d;
                    div_cnt_q <= div_cnt_q + 5'd1;
                    if (div_cnt_q == 5'd31) begin
                        res_q   <= (op_q == OP_REMU) ? div_rem_d : div_quo_d;
                        state_q <= S_WB;
                    end
                end
`endif
                S_TRAP: begin
                    trap_q <= 1'b1;
                    we_q   <= 1'b0;
                    re_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_TRAP;
                    trap_q  <= 1'b1;
                end
            endcase
        end
    end

    assign PC             = pc_q;
    assign instr_req      = (state_q == S_FETCH);
    assign WE             = we_q;
    assign RE             = re_q;
    assign address_to_mem = addr_q;
    assign data_to_mem    = wdata_q;
    assign retire         = retire_q;
    assign trap           = trap_q;
    assign dbg_state_o    = state_q;

endmodule
